sram_mem_controller: RTL



---
 rtl/sram_mem_controller.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sram_mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_controller
// Purpose  : Splits 32-bit MEM-stage loads/stores into two 16-bit accesses on
//            an asynchronous SRAM and freezes the pipeline while they run.
// Revision : 1.0 - initial release
// ============================================================================
module sram_mem_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18,
    parameter int HALF_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic               sram_freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam logic [3:0] c_last = 4'(HALF_CYCLES - 1);

    if (HALF_CYCLES < 2 || HALF_CYCLES > 15) begin : g_bad_half_cycles
        $error("sram_mem_controller: HALF_CYCLES must be 2..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               r_state, w_state_n;
    logic [3:0]           r_cnt, w_cnt_n;
    logic                 r_op, w_op_n;          // 1 = write
    logic [SRAM_AW-2:0]   r_widx, w_widx_n;
    logic [31:0]          r_wdata, w_wdata_n;

    logic [31:0]          r_read_data;
    logic                 r_ready, w_ready_n;
    logic [SRAM_AW-1:0]   r_sram_addr, w_sram_addr_n;
    logic [15:0]          r_dq_out, w_dq_out_n;
    logic                 r_dq_oe, w_dq_oe_n;
    logic                 r_we_n, w_we_n_n;
    logic                 r_oe_n, w_oe_n_n;

    logic [31:0]          w_offset;
    logic [SRAM_AW-2:0]   w_widx_in;
    logic                 w_unused_offset_bits;
    logic                 w_req;
    logic                 w_cap_lo, w_cap_hi;

    assign w_req     = wr_en | rd_en;
    assign w_offset  = address - 32'(BASE_ADDR);
    assign w_widx_in = w_offset[SRAM_AW:2];
    assign w_unused_offset_bits = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

    // Read halves are sampled on the last cycle of each half, when the SRAM
    // output has had the full half period to settle.
    assign w_cap_lo = (r_state == LO) && !r_op && (r_cnt == c_last);
    assign w_cap_hi = (r_state == HI) && !r_op && (r_cnt == c_last);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_op_n    = r_op;
        w_widx_n  = r_widx;
        w_wdata_n = r_wdata;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_n = LO;
                    w_cnt_n   = 4'd0;
                    w_op_n    = wr_en;
                    w_widx_n  = w_widx_in;
                    w_wdata_n = write_data;
                end
            end
            LO: begin
                if (r_cnt == c_last) begin
                    w_state_n = HI;
                    w_cnt_n   = 4'd0;
                end else begin
                    w_cnt_n = r_cnt + 4'd1;
                end
            end
            HI: begin
                if (r_cnt == c_last) begin
                    w_state_n = DONE;
                    w_cnt_n   = 4'd0;
                end else begin
                    w_cnt_n = r_cnt + 4'd1;
                end
            end
            DONE:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // Pin values are computed for the upcoming state so every SRAM strobe
    // leaves a flop and cannot glitch.
    always_comb begin
        w_sram_addr_n = r_sram_addr;
        w_dq_out_n    = r_dq_out;
        w_dq_oe_n     = 1'b0;
        w_we_n_n      = 1'b1;
        w_oe_n_n      = 1'b1;
        w_ready_n     = (w_state_n == DONE);
        if (w_state_n == LO || w_state_n == HI) begin
            w_sram_addr_n = {w_widx_n, (w_state_n == HI)};
            if (w_op_n) begin
                w_dq_out_n = (w_state_n == HI) ? w_wdata_n[31:16] : w_wdata_n[15:0];
                w_dq_oe_n  = 1'b1;
                w_we_n_n   = (w_cnt_n == c_last);
            end else begin
                w_oe_n_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_op        <= 1'b0;
            r_widx      <= '0;
            r_wdata     <= 32'd0;
            r_read_data <= 32'd0;
            r_ready     <= 1'b0;
            r_sram_addr <= '0;
            r_dq_out    <= 16'd0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_op        <= w_op_n;
            r_widx      <= w_widx_n;
            r_wdata     <= w_wdata_n;
            r_ready     <= w_ready_n;
            r_sram_addr <= w_sram_addr_n;
            r_dq_out    <= w_dq_out_n;
            r_dq_oe     <= w_dq_oe_n;
            r_we_n      <= w_we_n_n;
            r_oe_n      <= w_oe_n_n;
            if (w_cap_lo) r_read_data[15:0]  <= sram_dq_in;
            if (w_cap_hi) r_read_data[31:16] <= sram_dq_in;
        end
    end

    assign sram_freeze = ((r_state == IDLE) && w_req) || (r_state == LO) || (r_state == HI);
    assign read_data   = r_read_data;
    assign ready       = r_ready;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;
    assign sram_oe_n   = r_oe_n;

endmodule
`default_nettype wire
